// File: rtl/vrf_read_port_arbiter.sv
// vrf_read_port_arbiter
//
// Shares one VRF bank read port among NUM_REQ requesters (lane stages, LSU,
// cross-lane read units). Selection is round-robin; a requester that is
// granted while the port stalls keeps the grant until it fires or drops its
// request. Every fired read is tracked through a READ_LATENCY-deep pipeline
// so the returning read data can be flagged for the requester that issued it.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high. vrf_valid never waits for vrf_ready. req_ready[i] is high only on the
// cycle requester i's request is taken by the VRF port. Once a requester is
// stalled, its grant and forwarded fields stay stable while it holds valid.
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   req_valid / req_ready      per-requester request handshake
//   req_vs, req_readSource,
//   req_offset,
//   req_instructionIndex       packed per-requester fields (requester i in
//                              slice i of each bus)
//   vrf_valid / vrf_ready      request handshake toward the VRF read port
//   vrf_vs, vrf_readSource,
//   vrf_offset,
//   vrf_instructionIndex       fields of the granted requester (0 when idle)
//   vrf_readData               VRF data, valid READ_LATENCY cycles after fire
//   resp_valid                 one-hot: vrf_readData belongs to requester i
//   resp_data                  read data, shared by all requesters
//   busy                       any read still in the latency pipeline

module vrf_read_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2,
    parameter int DATA_W       = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*5-1:0]   req_vs,
    input  logic [NUM_REQ*2-1:0]   req_readSource,
    input  logic [NUM_REQ*2-1:0]   req_offset,
    input  logic [NUM_REQ*3-1:0]   req_instructionIndex,
    output logic                   vrf_valid,
    input  logic                   vrf_ready,
    output logic [4:0]             vrf_vs,
    output logic [1:0]             vrf_readSource,
    output logic [1:0]             vrf_offset,
    output logic [2:0]             vrf_instructionIndex,
    input  logic [DATA_W-1:0]      vrf_readData,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAST  = READ_LATENCY - 1;

    // Arbitration state: round-robin pointer plus the stall lock.
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic             lock_valid, lock_valid_nxt;
    logic [IDX_W-1:0] lock_idx, lock_idx_nxt;

    logic [IDX_W-1:0] grant;
    logic             fire;

    // Latency pipeline: stage 0 is loaded on the fire cycle.
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [IDX_W-1:0]        pipe_idx [READ_LATENCY];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else begin
            rr_ptr     <= rr_ptr_nxt;
            lock_valid <= lock_valid_nxt;
            lock_idx   <= lock_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_nxt     = rr_ptr;
        lock_valid_nxt = 1'b0;
        lock_idx_nxt   = lock_idx;
        if (fire) begin
            // Explicit wrap so non-power-of-two NUM_REQ stays in range.
            rr_ptr_nxt = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
        end else if (vrf_valid) begin
            lock_valid_nxt = 1'b1;
            lock_idx_nxt   = grant;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: grant selection and forwarded fields
    // ------------------------------------------------------------------
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        cand  = '0;
        grant = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr) + k >= NUM_REQ) begin
                cand = IDX_W'(int'(rr_ptr) + k - NUM_REQ);
            end else begin
                cand = IDX_W'(int'(rr_ptr) + k);
            end
            if (!found && req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        // A stalled requester that still holds valid keeps the port; if it
        // dropped valid the lock simply stops applying this cycle.
        if (lock_valid && req_valid[lock_idx]) begin
            grant = lock_idx;
        end
    end

    assign vrf_valid = |req_valid;
    assign fire      = vrf_valid & vrf_ready;

    always_comb begin
        vrf_vs               = '0;
        vrf_readSource       = '0;
        vrf_offset           = '0;
        vrf_instructionIndex = '0;
        if (vrf_valid) begin
            vrf_vs               = req_vs[int'(grant)*5 +: 5];
            vrf_readSource       = req_readSource[int'(grant)*2 +: 2];
            vrf_offset           = req_offset[int'(grant)*2 +: 2];
            vrf_instructionIndex = req_instructionIndex[int'(grant)*3 +: 3];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = fire && (grant == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Read latency pipeline (no back-pressure, shifts every cycle)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_idx[s]   <= '0;
            end
        end else begin
            pipe_valid[0] <= fire;
            pipe_idx[0]   <= grant;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_idx[s]   <= pipe_idx[s-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = pipe_valid[LAST] && (pipe_idx[LAST] == IDX_W'(i));
        end
    end

    assign resp_data = vrf_readData;
    assign busy      = |pipe_valid;

endmodule

// File: doc/vrf_read_port_arbiter.md
Name: vrf_read_port_arbiter

Overview:
- Shares one VRF read port among NUM_REQ requesters, such as lane stages, the LSU and cross-lane read units.
- Arbitration is round-robin with grant lock while the port is stalled.
- The block tracks each granted read through a fixed-latency read pipeline and returns the read data to the requester that issued it.
- It sits between the per-lane read requesters and the VRF bank read port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- READ_LATENCY, 2, cycles from VRF port fire to vrf_readData valid (1..4).
- DATA_W, 32, read data width.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted.
- req_vs  in  NUM_REQ*5  vector register index, packed with requester i at [5i+4:5i].
- req_readSource  in  NUM_REQ*2  read source tag, packed.
- req_offset  in  NUM_REQ*2  element-group offset, packed.
- req_instructionIndex  in  NUM_REQ*3  instruction index, packed.
- vrf_valid  out  1  request to VRF port.
- vrf_ready  in  1  VRF port accepts.
- vrf_vs  out  5  forwarded field of the granted requester.
- vrf_readSource  out  2  forwarded field of the granted requester.
- vrf_offset  out  2  forwarded field of the granted requester.
- vrf_instructionIndex  out  3  forwarded field of the granted requester.
- vrf_readData  in  DATA_W  read data, valid READ_LATENCY cycles after fire.
- resp_valid  out  NUM_REQ  one-hot, read data is for requester i.
- resp_data  out  DATA_W  read data, shared by all requesters.
- busy  out  1  any read in flight in the latency pipeline.

Behaviour:
- Reset: clock and reset are the only timing inputs; clock has one domain and reset is synchronous, active-high.
  - On reset: rr_ptr = 0, lock_valid = 0, lock_idx = 0, all pipeline stages invalid.
  - Combinational outputs after reset: resp_valid = 0, busy = 0, req_ready = 0 unless the grant rules below apply.
- Grant selection (combinational):
  - If lock_valid is set and req_valid[lock_idx] is high, grant = lock_idx.
  - Otherwise grant = the first i with req_valid[i] high, searching circularly from rr_ptr.
  - vrf_valid = OR of req_valid. The vrf_* fields are taken from the granted requester and are 0 when vrf_valid = 0.
  - req_ready[i] = vrf_ready AND vrf_valid AND (grant == i). It does not depend on vrf_ready combinationally beyond this AND.
- Fire (vrf_valid AND vrf_ready):
  - rr_ptr <= (grant + 1) mod NUM_REQ. When NUM_REQ is not a power of two, wrap explicitly.
  - lock_valid <= 0.
  - Pipeline stage 0 <= {valid = 1, idx = grant}.
- Stall (vrf_valid AND NOT vrf_ready):
  - lock_valid <= 1, lock_idx <= grant.
  - The grant and its fields stay stable while the locked requester holds valid.
  - If the locked requester drops valid, the lock is released that cycle and normal round-robin selection applies. The block does not treat this as an error.
- No request: lock_valid <= 0 and rr_ptr is unchanged.
- Latency pipeline:
  - READ_LATENCY stages of {valid, idx}, shifting every cycle with no back-pressure. A stage with no fire loads invalid.
  - resp_valid[i] = last stage valid AND idx == i. resp_data = vrf_readData (pass-through, never registered).
  - busy = OR of all stage valids.
- Throughput: one grant per cycle. Back-to-back fires from different requesters produce responses on consecutive cycles, in grant order.
- Simultaneous events:
  - A fire and a response retiring in the same cycle are independent.
  - A requester may fire again while its earlier read is in flight.
- Reset mid-operation: in-flight reads are dropped and no resp_valid is produced for them. Requesters re-issue.
- Arithmetic: rr_ptr and idx are clog2(NUM_REQ) bits wide (1 bit minimum).

Test Plan:
- Single requester: req_valid = 4'b0100, vs = 7, vrf_ready = 1.
  - Required: vrf_vs = 7 and req_ready[2] = 1 in cycle 0.
  - Required: resp_valid = 4'b0100 in cycle 2, with resp_data equal to vrf_readData.
- All four requesters held valid, vrf_ready = 1.
  - Required: grants 0,1,2,3,0 on successive cycles.
  - Required: responses one-hot in the same order, two cycles later.
- Stall lock: rr_ptr = 1, req_valid = 4'b0011, vrf_ready = 0 for 3 cycles, then 1.
  - Required: grant stays 1 for all 4 cycles, with fields unchanged.
  - Required: fire on requester 1, then rr_ptr = 2, and the next grant is 0.
- Lock release: stall with grant 3, then req_valid[3] drops while req_valid[0] = 1.
  - Required: grant switches to 0 in the same cycle.
- Reset mid-flight: fire on requester 1, then assert reset the next cycle.
  - Required: no resp_valid, busy = 0, rr_ptr = 0.
- NUM_REQ = 3, READ_LATENCY = 1: requesters 0..2 valid continuously.
  - Required: grant sequence 0,1,2,0, confirming the mod-3 wrap.
  - Required: each response arrives 1 cycle after its fire.
